// File: rtl/store_buffer_if.sv
// -----------------------------------------------------------------------------
// store_buffer_if
//   Bundles the store buffer's three traffic groups: the push side from the
//   Memory stage, the drain side toward the data-memory port, and the
//   load-forwarding query. The occupancy status travels with the bundle too.
//
//   Modports:
//     slave  - the store buffer itself
//     master - the surrounding pipeline / memory port (or a testbench)
//
//   Signals:
//     pushValid, pushAddress, pushData, pushByteEnable  : store offered
//     pushReady                                         : buffer can accept
//     storeValid, storeAddress, storeData,
//     storeByteEnable                                   : head presented
//     storeComplete                                     : memory took head
//     loadQueryValid, loadQueryAddress,
//     loadQueryByteEnable                               : load lookup
//     loadForwardHit, loadForwardData, loadConflict     : lookup result
//     empty, count                                      : occupancy
// -----------------------------------------------------------------------------
interface store_buffer_if #(
  parameter int DEPTH      = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  localparam int BE_WIDTH    = DATA_WIDTH / 8;
  localparam int COUNT_WIDTH = $clog2(DEPTH) + 1;

  logic                   pushValid;
  logic                   pushReady;
  logic [ADDR_WIDTH-1:0]  pushAddress;
  logic [DATA_WIDTH-1:0]  pushData;
  logic [BE_WIDTH-1:0]    pushByteEnable;

  logic                   storeValid;
  logic [ADDR_WIDTH-1:0]  storeAddress;
  logic [DATA_WIDTH-1:0]  storeData;
  logic [BE_WIDTH-1:0]    storeByteEnable;
  logic                   storeComplete;

  logic                   loadQueryValid;
  logic [ADDR_WIDTH-1:0]  loadQueryAddress;
  logic [BE_WIDTH-1:0]    loadQueryByteEnable;
  logic                   loadForwardHit;
  logic [DATA_WIDTH-1:0]  loadForwardData;
  logic                   loadConflict;

  logic                   empty;
  logic [COUNT_WIDTH-1:0] count;

  modport slave (
    input  pushValid, pushAddress, pushData, pushByteEnable,
    output pushReady,
    output storeValid, storeAddress, storeData, storeByteEnable,
    input  storeComplete,
    input  loadQueryValid, loadQueryAddress, loadQueryByteEnable,
    output loadForwardHit, loadForwardData, loadConflict,
    output empty, count
  );

  modport master (
    output pushValid, pushAddress, pushData, pushByteEnable,
    input  pushReady,
    input  storeValid, storeAddress, storeData, storeByteEnable,
    output storeComplete,
    output loadQueryValid, loadQueryAddress, loadQueryByteEnable,
    input  loadForwardHit, loadForwardData, loadConflict,
    input  empty, count
  );
endinterface

// File: rtl/store_buffer.sv
// -----------------------------------------------------------------------------
// store_buffer
//   In-order FIFO of committed stores sitting between the Memory stage and the
//   data-memory port. Stores retire into it immediately; the head entry is
//   offered to memory on storeValid and leaves on storeComplete. Younger loads
//   are looked up against every pending entry: full byte coverage forwards the
//   merged word, partial coverage flags a conflict so the stage can stall.
//
//   Ports:
//     clock  - rising-edge clock
//     reset  - asynchronous, active-low; clears pointers, count and entries
//     bus    - store_buffer_if.slave (push / drain / load-query / occupancy)
// -----------------------------------------------------------------------------
module store_buffer #(
  parameter int DEPTH      = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input logic           clock,
  input logic           reset,
  store_buffer_if.slave bus
);
  localparam int BE_WIDTH = DATA_WIDTH / 8;
  localparam int PW       = $clog2(DEPTH);
  localparam int CW       = PW + 1;
  // Clears the byte-offset bits so addresses compare at word granularity.
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~(ADDR_WIDTH'(BE_WIDTH - 1));

  // Entry storage, indexed by physical slot.
  logic [ADDR_WIDTH-1:0] addr_r  [DEPTH];
  logic [DATA_WIDTH-1:0] data_r  [DEPTH];
  logic [BE_WIDTH-1:0]   be_r    [DEPTH];
  logic [DEPTH-1:0]      valid_r;

  logic [PW-1:0]         head_r;
  logic [PW-1:0]         tail_r;
  logic [CW-1:0]         count_r;

  // Registered copy of the head entry presented to memory.
  logic [ADDR_WIDTH-1:0] head_addr_r, head_addr_s;
  logic [DATA_WIDTH-1:0] head_data_r, head_data_s;
  logic [BE_WIDTH-1:0]   head_be_r,   head_be_s;

  logic                  push_ready_s;
  logic                  push_s;
  logic                  pop_s;
  logic [PW-1:0]         next_head_s;

  // Forwarding helpers: slot of the i-th oldest entry and whether it matches.
  logic [PW-1:0]         age_idx_s [DEPTH];
  logic [DEPTH-1:0]      match_s;
  logic [DATA_WIDTH-1:0] merged_s;
  logic [BE_WIDTH-1:0]   covered_s;
  logic [BE_WIDTH-1:0]   req_cov_s;
  logic                  fwd_hit_s;
  logic                  fwd_conflict_s;
  logic [DATA_WIDTH-1:0] fwd_data_s;

  // No same-cycle bypass: a pop this cycle does not free room for a push.
  assign push_ready_s = (count_r < CW'(DEPTH));
  assign push_s       = bus.pushValid && push_ready_s;
  assign pop_s        = bus.storeComplete && (count_r != CW'(0));
  assign next_head_s  = head_r + PW'(1);

  // Pointer, occupancy and entry-array update.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      head_r  <= '0;
      tail_r  <= '0;
      count_r <= '0;
      valid_r <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        addr_r[i] <= '0;
        data_r[i] <= '0;
        be_r[i]   <= '0;
      end
    end else begin
      if (push_s) begin
        addr_r[tail_r]  <= bus.pushAddress & ALIGN_MASK;
        data_r[tail_r]  <= bus.pushData;
        be_r[tail_r]    <= bus.pushByteEnable;
        valid_r[tail_r] <= 1'b1;
        tail_r          <= tail_r + PW'(1);
      end
      // Push and pop can only share a slot when empty or full, neither of
      // which allows both, so these two valid_r writes never collide.
      if (pop_s) begin
        valid_r[head_r] <= 1'b0;
        head_r          <= next_head_s;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Next value of the registered head: the following slot after a pop, or
  // the incoming store when it lands in (or becomes) the only entry.
  always_comb begin
    head_addr_s = head_addr_r;
    head_data_s = head_data_r;
    head_be_s   = head_be_r;
    if (pop_s) begin
      if (count_r > CW'(1)) begin
        head_addr_s = addr_r[next_head_s];
        head_data_s = data_r[next_head_s];
        head_be_s   = be_r[next_head_s];
      end else if (push_s) begin
        head_addr_s = bus.pushAddress & ALIGN_MASK;
        head_data_s = bus.pushData;
        head_be_s   = bus.pushByteEnable;
      end else begin
        head_addr_s = '0;
        head_data_s = '0;
        head_be_s   = '0;
      end
    end else if (push_s && (count_r == CW'(0))) begin
      head_addr_s = bus.pushAddress & ALIGN_MASK;
      head_data_s = bus.pushData;
      head_be_s   = bus.pushByteEnable;
    end else begin
      head_addr_s = head_addr_r;
      head_data_s = head_data_r;
      head_be_s   = head_be_r;
    end
  end

  // Head output registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      head_addr_r <= '0;
      head_data_r <= '0;
      head_be_r   <= '0;
    end else begin
      head_addr_r <= head_addr_s;
      head_data_r <= head_data_s;
      head_be_r   <= head_be_s;
    end
  end

  // Age ordering (0 = oldest) and word-address match per pending entry.
  always_comb begin
    match_s = '0;
    for (int i = 0; i < DEPTH; i++) begin
      age_idx_s[i] = head_r + PW'(i);
      match_s[i]   = valid_r[age_idx_s[i]] &&
                     (addr_r[age_idx_s[i]] == (bus.loadQueryAddress & ALIGN_MASK));
    end
  end

  // Merge matching entries oldest to youngest so younger bytes overwrite.
  always_comb begin
    merged_s  = '0;
    covered_s = '0;
    for (int i = 0; i < DEPTH; i++) begin
      for (int b = 0; b < BE_WIDTH; b++) begin
        if (match_s[i] && be_r[age_idx_s[i]][b]) begin
          merged_s[b*8 +: 8] = data_r[age_idx_s[i]][b*8 +: 8];
          covered_s[b]       = 1'b1;
        end else begin
          merged_s[b*8 +: 8] = merged_s[b*8 +: 8];
          covered_s[b]       = covered_s[b];
        end
      end
    end
  end

  // Classify the lookup; unrequested bytes are zeroed in the forwarded word.
  always_comb begin
    req_cov_s      = covered_s & bus.loadQueryByteEnable;
    fwd_hit_s      = 1'b0;
    fwd_conflict_s = 1'b0;
    fwd_data_s     = '0;
    if (bus.loadQueryValid) begin
      fwd_hit_s      = (req_cov_s == bus.loadQueryByteEnable) && (req_cov_s != '0);
      fwd_conflict_s = (req_cov_s != '0) && (req_cov_s != bus.loadQueryByteEnable);
      for (int b = 0; b < BE_WIDTH; b++) begin
        fwd_data_s[b*8 +: 8] = merged_s[b*8 +: 8] & {8{bus.loadQueryByteEnable[b]}};
      end
    end else begin
      fwd_hit_s      = 1'b0;
      fwd_conflict_s = 1'b0;
      fwd_data_s     = '0;
    end
  end

  assign bus.pushReady       = push_ready_s;
  assign bus.storeValid      = (count_r != CW'(0));
  assign bus.storeAddress    = head_addr_r;
  assign bus.storeData       = head_data_r;
  assign bus.storeByteEnable = head_be_r;
  assign bus.loadForwardHit  = fwd_hit_s;
  assign bus.loadConflict    = fwd_conflict_s;
  assign bus.loadForwardData = fwd_data_s;
  assign bus.empty           = (count_r == CW'(0));
  assign bus.count           = count_r;

endmodule

// File: tb/tb_store_buffer.sv
// -----------------------------------------------------------------------------
// tb_store_buffer
//   Directed bench for store_buffer (DEPTH=4, 32-bit address/data). A queue
//   model of pending stores predicts every output each cycle; a few literal
//   expectations pin the model to hand-computed values.
// -----------------------------------------------------------------------------
module tb_store_buffer;
  logic clock;
  logic reset;

  store_buffer_if #(.DEPTH(4), .ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  store_buffer #(.DEPTH(4), .ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
  } st_t;

  st_t         q[$];
  logic [31:0] pop_log[$];
  int          checks = 0;
  int          errors = 0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Compare every meaningful output against the queue model.
  task automatic check_outputs();
    logic [3:0]  cov;
    logic [31:0] fd;
    logic [3:0]  qbe;
    logic        eh, ec;
    int          n;
    n   = q.size();
    qbe = bus.loadQueryByteEnable;
    chk("pushReady", bus.pushReady, n < 4);
    chk("storeValid", bus.storeValid, n > 0);
    chk("empty", bus.empty, n == 0);
    chk("count", bus.count, n);
    if (n > 0) begin
      chk("storeAddress", bus.storeAddress, q[0].addr & 32'hFFFF_FFFC);
      chk("storeData", bus.storeData, q[0].data);
      chk("storeByteEnable", bus.storeByteEnable, q[0].be);
    end
    cov = 4'h0;
    fd  = 32'h0;
    if (bus.loadQueryValid) begin
      for (int b = 0; b < 4; b++) begin
        if (qbe[b]) begin
          for (int k = n - 1; k >= 0; k--) begin
            if (!cov[b] && q[k].addr[31:2] == bus.loadQueryAddress[31:2] && q[k].be[b]) begin
              fd[b*8 +: 8] = q[k].data[b*8 +: 8];
              cov[b]       = 1'b1;
            end
          end
        end
      end
    end
    eh = bus.loadQueryValid && (cov == qbe) && (cov != 4'h0);
    ec = bus.loadQueryValid && (cov != 4'h0) && (cov != qbe);
    chk("loadForwardHit", bus.loadForwardHit, eh);
    chk("loadConflict", bus.loadConflict, ec);
    chk("loadForwardData", bus.loadForwardData, fd);
    if (bus.storeComplete && bus.storeValid) pop_log.push_back(bus.storeAddress);
  endtask

  // Apply the clock edge to the model using the inputs held across it.
  task automatic model_update();
    logic push_ok, pop_ok;
    st_t  e;
    if (reset) begin
      push_ok = bus.pushValid && (q.size() < 4);
      pop_ok  = bus.storeComplete && (q.size() > 0);
      if (pop_ok) q.delete(0);
      if (push_ok) begin
        e.addr = bus.pushAddress;
        e.data = bus.pushData;
        e.be   = bus.pushByteEnable;
        q.push_back(e);
      end
    end
  endtask

  task automatic tick();
    @(negedge clock);
    check_outputs();
    @(posedge clock);
    model_update();
    #1;
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    bus.pushValid      = 1'b1;
    bus.pushAddress    = a;
    bus.pushData       = d;
    bus.pushByteEnable = be;
  endtask

  task automatic idle();
    bus.pushValid           = 1'b0;
    bus.pushAddress         = 32'h0;
    bus.pushData            = 32'h0;
    bus.pushByteEnable      = 4'h0;
    bus.storeComplete       = 1'b0;
    bus.loadQueryValid      = 1'b0;
    bus.loadQueryAddress    = 32'h0;
    bus.loadQueryByteEnable = 4'h0;
  endtask

  task automatic query(input logic [31:0] a, input logic [3:0] be);
    bus.loadQueryValid      = 1'b1;
    bus.loadQueryAddress    = a;
    bus.loadQueryByteEnable = be;
  endtask

  // Complete until the buffer is empty, bounded to a few cycles.
  task automatic drain();
    bus.pushValid     = 1'b0;
    bus.storeComplete = 1'b1;
    for (int n = 0; n < 16; n++) begin
      if (!bus.storeValid) break;
      tick();
    end
    bus.storeComplete = 1'b0;
    chk("drain_empty", bus.empty, 1'b1);
  endtask

  initial begin
    reset = 1'b0;
    idle();
    repeat (2) tick();
    reset = 1'b1;
    tick();
    chk("rst_pushReady", bus.pushReady, 1'b1);
    chk("rst_empty", bus.empty, 1'b1);
    chk("rst_storeValid", bus.storeValid, 1'b0);

    // storeComplete while empty is ignored
    bus.storeComplete = 1'b1;
    tick();
    bus.storeComplete = 1'b0;
    chk("complete_empty_count", bus.count, 3'd0);

    // Fill to DEPTH, then a fifth push is held off
    for (int i = 0; i < 4; i++) begin
      push(32'h10 + 32'(i * 4), 32'h1000_0000 + 32'(i), 4'hF);
      tick();
    end
    push(32'h20, 32'hDEAD_BEEF, 4'hF);
    tick();
    idle();
    chk("full_count", bus.count, 3'd4);
    chk("full_pushReady", bus.pushReady, 1'b0);
    chk("full_head_addr", bus.storeAddress, 32'h10);
    chk("full_head_data", bus.storeData, 32'h1000_0000);

    // Reset mid-drain with three entries pending
    bus.storeComplete = 1'b1;
    tick();
    bus.storeComplete = 1'b0;
    chk("pre_reset_count", bus.count, 3'd3);
    reset = 1'b0;
    q.delete();
    #1;
    chk("rst_mid_storeValid", bus.storeValid, 1'b0);
    chk("rst_mid_count", bus.count, 3'd0);
    chk("rst_mid_empty", bus.empty, 1'b1);
    chk("rst_mid_pushReady", bus.pushReady, 1'b1);
    tick();
    reset = 1'b1;
    tick();

    // Six pushes with interleaved completes; tail wraps past slot 3
    pop_log.delete();
    for (int i = 0; i < 6; i++) begin
      push(32'h40 + 32'(i * 4), 32'h3000_0000 + 32'(i), 4'hF);
      bus.storeComplete = (i % 2 == 1);
      tick();
    end
    idle();
    drain();
    chk("order_len", pop_log.size(), 6);
    for (int k = 0; k < 6 && k < pop_log.size(); k++) begin
      chk("order_addr", pop_log[k], 32'h40 + 32'(k * 4));
    end

    // Simultaneous push and pop at count 2
    push(32'h80, 32'h8000_0000, 4'hF);
    tick();
    push(32'h84, 32'h8400_0000, 4'hF);
    tick();
    push(32'h88, 32'h8800_0000, 4'hF);
    bus.storeComplete = 1'b1;
    tick();
    idle();
    chk("pushpop_count", bus.count, 3'd2);
    chk("pushpop_head", bus.storeAddress, 32'h84);
    drain();

    // Forwarding: SW then SB override, queried while the first push lands
    query(32'h100, 4'hF);
    push(32'h100, 32'hAABB_CCDD, 4'hF);
    tick();
    push(32'h101, 32'h0000_1100, 4'b0010);
    tick();
    bus.pushValid = 1'b0;
    chk("fwd_hit", bus.loadForwardHit, 1'b1);
    chk("fwd_data", bus.loadForwardData, 32'hAABB_11DD);
    chk("fwd_conflict", bus.loadConflict, 1'b0);
    tick();
    query(32'h102, 4'b1100);
    tick();
    chk("fwd_half_data", bus.loadForwardData, 32'hAABB_0000);
    idle();
    tick();
    drain();

    // Conflict: SB covers one byte of a full-word load
    push(32'h200, 32'h0000_00EE, 4'b0001);
    tick();
    bus.pushValid = 1'b0;
    query(32'h200, 4'hF);
    #1;
    chk("conf_conflict", bus.loadConflict, 1'b1);
    chk("conf_hit", bus.loadForwardHit, 1'b0);
    tick();
    bus.loadQueryValid = 1'b0;
    #1;
    chk("noquery_conflict", bus.loadConflict, 1'b0);
    chk("noquery_data", bus.loadForwardData, 32'h0);
    tick();
    query(32'h300, 4'hF);
    #1;
    chk("miss_hit", bus.loadForwardHit, 1'b0);
    chk("miss_conflict", bus.loadConflict, 1'b0);
    tick();
    query(32'h200, 4'hF);
    bus.storeComplete = 1'b1;
    tick();
    bus.storeComplete = 1'b0;
    chk("drained_conflict", bus.loadConflict, 1'b0);
    chk("drained_hit", bus.loadForwardHit, 1'b0);
    tick();
    idle();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
